ssk_kdf_seq: RTL and testbench

Key-block expansion sequencer that sits directly upstream of the session-key core.
- Runs the P_hash chain on an external HMAC-SHA384 engine. Each block takes two HMAC operations: A(i)=HMAC(A(i-1)), then P(i)=HMAC(A(i)||seed).
- Writes each 384-bit P(i) into the session-key memory through the core's ssk_wr/ssk_addr/mac write port, at addresses 0..num_blk-1.
- Aborts cleanly on session clear or expiry.

---
 rtl/ssk_kdf_seq.sv | 190 +++++++++++++++++++
 tb/tb_ssk_kdf_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssk_kdf_seq.sv
`default_nettype none
// ==========================================================================
// ssk_kdf_seq : P_hash key-block sequencer feeding the session-key memory.
//   Optional watchdog macro: SSK_KDF_TMO_EN.        Revision 1.0
// ==========================================================================
module ssk_kdf_seq #(
  parameter int AW       = 4,
  parameter int DW       = 384,
  parameter int NBLK_MAX = 4
`ifdef SSK_KDF_TMO_EN
  ,
  parameter int TMO_CYC  = 1024
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] num_blk,
  input  logic          clr_ssk,
  input  logic          ss_expire,
  output logic          hm_start,
  output logic          hm_phase,
  output logic [DW-1:0] hm_a,
  input  logic          hm_done,
  input  logic [DW-1:0] hm_dout,
  output logic          ssk_wr,
  output logic [AW-1:0] ssk_addr,
  output logic [DW-1:0] mac,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_A_REQ  = 3'd1;
  localparam logic [2:0] S_A_WAIT = 3'd2;
  localparam logic [2:0] S_P_REQ  = 3'd3;
  localparam logic [2:0] S_P_WAIT = 3'd4;
  localparam logic [2:0] S_WR     = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [AW-1:0] NBLK_MAX_W = AW'(NBLK_MAX);
  localparam logic [AW-1:0] ONE_W      = AW'(1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] num_q, num_d;
  logic [AW-1:0] blk_idx_q, blk_idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] mac_q, mac_d;
  logic          err_q, err_d;

  logic abort;
  logic start_ok;
  logic last_blk;
  logic in_wait;
  logic tmo_hit;

  assign abort    = clr_ssk | ss_expire;
  assign start_ok = (num_blk != '0) && (num_blk <= NBLK_MAX_W);
  assign last_blk = (blk_idx_q == (num_q - ONE_W));
  assign in_wait  = (state_q == S_A_WAIT) || (state_q == S_P_WAIT);

`ifdef SSK_KDF_TMO_EN
  localparam int            TW       = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Counter is held at zero outside the WAIT states, so each WAIT starts fresh.
  always_comb begin
    tmo_d = '0;
    if (in_wait) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign tmo_hit = in_wait && !hm_done && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    blk_idx_d = blk_idx_q;
    addr_d    = addr_q;
    a_d       = a_q;
    mac_d     = mac_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            num_d     = num_blk;
            blk_idx_d = '0;
            state_d   = S_A_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_A_REQ:  state_d = S_A_WAIT;
      S_A_WAIT: begin
        if (hm_done) begin
          a_d     = hm_dout;
          state_d = S_P_REQ;
        end
      end
      S_P_REQ:  state_d = S_P_WAIT;
      S_P_WAIT: begin
        if (hm_done) begin
          mac_d   = hm_dout;
          addr_d  = blk_idx_q;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (last_blk) begin
          state_d = S_DONE;
        end else begin
          blk_idx_d = blk_idx_q + ONE_W;
          state_d   = S_A_REQ;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      state_d   = S_IDLE;
      blk_idx_d = '0;
      addr_d    = '0;
      a_d       = '0;
      mac_d     = '0;
      err_d     = 1'b1;
    end

    // Abort wins over everything, including a pending start or timeout.
    if (abort) begin
      state_d   = S_IDLE;
      blk_idx_d = '0;
      addr_d    = '0;
      a_d       = '0;
      mac_d     = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      blk_idx_q <= '0;
      addr_q    <= '0;
      a_q       <= '0;
      mac_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      blk_idx_q <= blk_idx_d;
      addr_q    <= addr_d;
      a_q       <= a_d;
      mac_q     <= mac_d;
      err_q     <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign hm_start = ((state_q == S_A_REQ) || (state_q == S_P_REQ)) && !abort;
  assign hm_phase = (state_q == S_P_REQ) || (state_q == S_P_WAIT);
  assign ssk_wr   = (state_q == S_WR) && !abort;
  assign done     = (state_q == S_DONE) && !abort;
  assign err      = err_q;
  assign hm_a     = a_q;
  assign mac      = mac_q;
  assign ssk_addr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ssk_kdf_seq.sv
`default_nettype none
// ==========================================================================
// tb_ssk_kdf_seq : directed bench for ssk_kdf_seq with a fixed-latency engine.
//   Revision 1.0
// ==========================================================================
module tb_ssk_kdf_seq;

  localparam int AW = 4;
  localparam int DW = 384;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_blk;
  logic          clr_ssk;
  logic          ss_expire;
  logic          hm_start;
  logic          hm_phase;
  logic [DW-1:0] hm_a;
  logic          hm_done;
  logic [DW-1:0] hm_dout;
  logic          ssk_wr;
  logic [AW-1:0] ssk_addr;
  logic [DW-1:0] mac;
  logic          busy;
  logic          done;
  logic          err;

  ssk_kdf_seq #(
    .AW(AW),
    .DW(DW),
    .NBLK_MAX(4)
`ifdef SSK_KDF_TMO_EN
    ,
    .TMO_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_blk(num_blk),
    .clr_ssk(clr_ssk), .ss_expire(ss_expire),
    .hm_start(hm_start), .hm_phase(hm_phase), .hm_a(hm_a),
    .hm_done(hm_done), .hm_dout(hm_dout),
    .ssk_wr(ssk_wr), .ssk_addr(ssk_addr), .mac(mac),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Records written by the monitor and engine; the main sequence only reads them.
  int            cyc      = 0;
  int            n_busy   = 0;
  int            n_wr     = 0;
  int            n_done   = 0;
  int            n_err    = 0;
  int            done_cyc = 0;
  int            err_cyc  = 0;
  int            wr_cyc  [64];
  logic [AW-1:0] wr_addr [64];
  logic [DW-1:0] wr_mac  [64];

  int            launches = 0;
  logic          st_phase [64];
  logic [DW-1:0] st_a     [64];
  int            eng_cnt  = 0;
  int            eng_id   = 0;
  int            eng_lat  = 5;
  bit            eng_en   = 1'b1;

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(k);
    return {12{w}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] n, output int s);
    start   = 1'b1;
    num_blk = n;
    s       = cyc + 1;
    tick();
    start   = 1'b0;
  endtask

  task automatic tick_until(input int target);
    for (int k = 0; k < 200 && (cyc + 1) < target; k++) tick();
  endtask

  // Engine: answers each launch eng_lat cycles later with pat(launch number).
  initial begin
    hm_done = 1'b0;
    hm_dout = '0;
    forever begin
      @(negedge clk);
      hm_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          hm_done = 1'b1;
          hm_dout = pat(eng_id);
        end
      end
      if (hm_start) begin
        launches++;
        st_phase[launches] = hm_phase;
        st_a[launches]     = hm_a;
        eng_id             = launches;
        eng_cnt            = eng_en ? eng_lat : 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (busy) n_busy++;
      if (ssk_wr) begin
        wr_addr[n_wr] = ssk_addr;
        wr_mac[n_wr]  = mac;
        wr_cyc[n_wr]  = cyc;
        n_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  initial begin
    int s, lb, wb, db, eb, bb;
    rst = 1'b1; start = 1'b0; num_blk = '0; clr_ssk = 1'b0; ss_expire = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_busy",   DW'(busy),     '0);
    chk("rst_hmst",   DW'(hm_start), '0);
    chk("rst_phase",  DW'(hm_phase), '0);
    chk("rst_wr",     DW'(ssk_wr),   '0);
    chk("rst_done",   DW'(done),     '0);
    chk("rst_err",    DW'(err),      '0);
    chk("rst_addr",   DW'(ssk_addr), '0);
    chk("rst_hm_a",   hm_a,          '0);
    chk("rst_mac",    mac,           '0);

    // Four-block run with L=5.
    lb = launches; wb = n_wr; db = n_done; eb = n_err;
    go(4'd4, s);
    repeat (60) tick();
    chk("t1_launches", DW'(launches - lb), DW'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_phase%0d", i), DW'(st_phase[lb+1+i]), DW'(i % 2));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_hm_a%0d", i), st_a[lb+2*i+2], pat(lb+2*i+1));
      chk($sformatf("t1_addr%0d", i), DW'(wr_addr[wb+i]), DW'(i));
      chk($sformatf("t1_mac%0d", i),  wr_mac[wb+i], pat(lb+2*i+2));
    end
    chk("t1_nwr",       DW'(n_wr - wb),   DW'(4));
    chk("t1_wr0_cyc",   DW'(wr_cyc[wb]),  DW'(s + 13));
    chk("t1_ndone",     DW'(n_done - db), DW'(1));
    chk("t1_done_gap",  DW'(done_cyc),    DW'(wr_cyc[wb+3] + 1));
    chk("t1_done_cyc",  DW'(done_cyc),    DW'(s + 53));
    chk("t1_nerr",      DW'(n_err - eb),  DW'(0));
    chk("t1_busy_end",  DW'(busy),        '0);

    // Illegal block counts.
    lb = launches; eb = n_err; bb = n_busy;
    go(4'd0, s);
    repeat (3) tick();
    chk("t2_err0_n",   DW'(n_err - eb), DW'(1));
    chk("t2_err0_cyc", DW'(err_cyc),    DW'(s + 1));
    go(4'd5, s);
    repeat (3) tick();
    chk("t2_err5_n",   DW'(n_err - eb),    DW'(2));
    chk("t2_err5_cyc", DW'(err_cyc),       DW'(s + 1));
    chk("t2_busy",     DW'(n_busy - bb),   DW'(0));
    chk("t2_launch",   DW'(launches - lb), DW'(0));

    // clr_ssk during block 1 P_WAIT (P_REQ at s+20, P_WAIT s+21..s+25).
    lb = launches; wb = n_wr; db = n_done; eb = n_err;
    go(4'd3, s);
    tick_until(s + 22);
    chk("t3_launch", DW'(launches - lb), DW'(4));
    clr_ssk = 1'b1;
    tick();
    clr_ssk = 1'b0;
    chk("t3_busy", DW'(busy), '0);
    chk("t3_hm_a", hm_a, '0);
    chk("t3_mac",  mac,  '0);
    repeat (8) tick();
    chk("t3_nwr",   DW'(n_wr - wb),      DW'(1));
    chk("t3_addr",  DW'(wr_addr[wb]),    '0);
    chk("t3_wmac",  wr_mac[wb],          pat(lb + 2));
    chk("t3_ndone", DW'(n_done - db),    DW'(0));
    chk("t3_nerr",  DW'(n_err - eb),     DW'(0));
    chk("t3_idle",  DW'(busy),           '0);

    // ss_expire coincident with block 1 WR at s+26.
    lb = launches; wb = n_wr; db = n_done; eb = n_err;
    go(4'd3, s);
    tick_until(s + 26);
    ss_expire = 1'b1;
    tick();
    ss_expire = 1'b0;
    repeat (3) tick();
    chk("t4_nwr",    DW'(n_wr - wb),      DW'(1));
    chk("t4_wr_cyc", DW'(wr_cyc[wb]),     DW'(s + 13));
    chk("t4_launch", DW'(launches - lb),  DW'(4));
    chk("t4_mac",    mac,                 '0);
    chk("t4_addr",   DW'(ssk_addr),       '0);
    chk("t4_busy",   DW'(busy),           '0);
    chk("t4_ndone",  DW'(n_done - db),    DW'(0));
    chk("t4_nerr",   DW'(n_err - eb),     DW'(0));

    // start while busy is ignored; original num_blk=2 is kept.
    lb = launches; wb = n_wr; db = n_done;
    go(4'd2, s);
    repeat (3) tick();
    start = 1'b1; num_blk = 4'd1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    chk("t5_nwr",      DW'(n_wr - wb),     DW'(2));
    chk("t5_addr1",    DW'(wr_addr[wb+1]), DW'(1));
    chk("t5_mac1",     wr_mac[wb+1],       pat(lb + 4));
    chk("t5_done_cyc", DW'(done_cyc),      DW'(s + 27));
    chk("t5_ndone",    DW'(n_done - db),   DW'(1));
    lb = launches; wb = n_wr;
    go(4'd1, s);
    repeat (20) tick();
    chk("t5b_nwr",      DW'(n_wr - wb),   DW'(1));
    chk("t5b_addr",     DW'(wr_addr[wb]), '0);
    chk("t5b_mac",      wr_mac[wb],       pat(lb + 2));
    chk("t5b_done_cyc", DW'(done_cyc),    DW'(s + 14));

`ifdef SSK_KDF_TMO_EN
    // Silent engine: A_WAIT entered at s+2, timeout err at s+18.
    wb = n_wr; db = n_done; eb = n_err;
    eng_en = 1'b0;
    go(4'd1, s);
    repeat (25) tick();
    chk("t6_nerr",   DW'(n_err - eb),  DW'(1));
    chk("t6_errcyc", DW'(err_cyc),     DW'(s + 18));
    chk("t6_busy",   DW'(busy),        '0);
    chk("t6_nwr",    DW'(n_wr - wb),   DW'(0));
    chk("t6_ndone",  DW'(n_done - db), DW'(0));
    eng_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
